// File: rtl/elevator_scan_scheduler_if.sv
// Request/status bundle between the request logic and the SCAN scheduler.
// The request logic is the master; the scheduler is the slave.
interface elevator_scan_scheduler_if #(
  parameter int unsigned N_FLOORS = 6,
  parameter int unsigned N_CARS   = 2,
  parameter int unsigned FLOOR_W  = $clog2(N_FLOORS)
);
  logic [N_CARS*N_FLOORS-1:0] req_i;
  logic [N_CARS*N_FLOORS-1:0] pending_o;
  logic [N_CARS*FLOOR_W-1:0]  car_floor_o;
  logic [N_CARS-1:0]          car_dir_o;
  logic [N_CARS-1:0]          moving_o;
  logic [N_CARS-1:0]          door_open_o;
  logic [N_CARS-1:0]          arrive_o;

  modport master (
    output req_i,
    input  pending_o, car_floor_o, car_dir_o, moving_o, door_open_o, arrive_o
  );

  modport slave (
    input  req_i,
    output pending_o, car_floor_o, car_dir_o, moving_o, door_open_o, arrive_o
  );
endinterface

// File: rtl/elevator_scan_scheduler.sv
// Multi-car SCAN elevator scheduler: latches per-car requests and runs one
// IDLE/MOVE/DWELL FSM per car with floor-travel and door-dwell timers.
module elevator_scan_scheduler #(
  parameter int unsigned N_FLOORS   = 6,
  parameter int unsigned N_CARS     = 2,
  parameter int unsigned TRAVEL_CYC = 60,
  parameter int unsigned DWELL_CYC  = 30,
  parameter int unsigned FLOOR_W    = $clog2(N_FLOORS)
) (
  input  logic                       clk,
  input  logic                       rst,
  elevator_scan_scheduler_if.slave   bus
);

  localparam int unsigned TMR_MAX = (TRAVEL_CYC > DWELL_CYC) ? TRAVEL_CYC : DWELL_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned NB      = N_CARS * N_FLOORS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  state_e               state_q [N_CARS];
  state_e               state_d [N_CARS];
  logic [FLOOR_W-1:0]   floor_q [N_CARS];
  logic [FLOOR_W-1:0]   floor_d [N_CARS];
  logic [TMR_W-1:0]     tmr_q   [N_CARS];
  logic [TMR_W-1:0]     tmr_d   [N_CARS];
  logic [N_CARS-1:0]    dir_q, dir_d;
  logic [N_CARS-1:0]    arrive_q, arrive_d;
  logic [N_CARS-1:0]    moving_q, door_q;
  logic [NB-1:0]        pending_q, pending_d;

  logic [N_FLOORS-1:0]  p_car;
  logic [N_FLOORS-1:0]  req_car;
  logic [N_FLOORS-1:0]  pend_next_car;
  logic [FLOOR_W-1:0]   new_floor;

  // True when any bit of p lies strictly above (up=1) or below (up=0) floor f.
  function automatic logic any_toward(input logic [N_FLOORS-1:0] p,
                                      input logic [FLOOR_W-1:0]  f,
                                      input logic                up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(N_FLOORS); i++) begin
      if (up && (FLOOR_W'(i) > f) && p[i]) r = 1'b1;
      if (!up && (FLOOR_W'(i) < f) && p[i]) r = 1'b1;
    end
    return r;
  endfunction

  // Next-state logic for every car plus the request latch with clear-over-set.
  always_comb begin
    pending_d     = pending_q | bus.req_i;
    p_car         = '0;
    req_car       = '0;
    pend_next_car = '0;
    new_floor     = '0;
    dir_d         = dir_q;
    arrive_d      = '0;
    for (int c = 0; c < int'(N_CARS); c++) begin
      state_d[c]    = state_q[c];
      floor_d[c]    = floor_q[c];
      tmr_d[c]      = tmr_q[c];
      p_car         = pending_q[c*N_FLOORS +: N_FLOORS];
      req_car       = bus.req_i[c*N_FLOORS +: N_FLOORS];
      pend_next_car = pending_d[c*N_FLOORS +: N_FLOORS];
      new_floor     = floor_q[c];

      unique case (state_q[c])
        ST_IDLE: begin
          tmr_d[c] = '0;
          if (p_car[floor_q[c]]) begin
            state_d[c] = ST_DWELL;
          end else if (any_toward(p_car, floor_q[c], dir_q[c])) begin
            state_d[c] = ST_MOVE;
          end else if (any_toward(p_car, floor_q[c], !dir_q[c])) begin
            state_d[c] = ST_MOVE;
            dir_d[c]   = !dir_q[c];
          end
        end

        ST_MOVE: begin
          if (tmr_q[c] == TMR_W'(TRAVEL_CYC - 1)) begin
            new_floor   = dir_q[c] ? floor_q[c] + FLOOR_W'(1) : floor_q[c] - FLOOR_W'(1);
            floor_d[c]  = new_floor;
            arrive_d[c] = 1'b1;
            tmr_d[c]    = '0;
            if (p_car[new_floor]) begin
              state_d[c] = ST_DWELL;
            end else if (any_toward(p_car, new_floor, dir_q[c])) begin
              state_d[c] = ST_MOVE;
            end else if (any_toward(p_car, new_floor, !dir_q[c])) begin
              state_d[c] = ST_MOVE;
              dir_d[c]   = !dir_q[c];
            end else begin
              state_d[c] = ST_IDLE;
            end
          end else begin
            tmr_d[c] = tmr_q[c] + TMR_W'(1);
          end
        end

        ST_DWELL: begin
          // A fresh call at the open door keeps it open rather than queueing.
          if (req_car[floor_q[c]]) begin
            tmr_d[c] = '0;
          end else if (tmr_q[c] == TMR_W'(DWELL_CYC - 1)) begin
            tmr_d[c] = '0;
            if (any_toward(p_car, floor_q[c], dir_q[c])) begin
              state_d[c] = ST_MOVE;
            end else if (any_toward(p_car, floor_q[c], !dir_q[c])) begin
              state_d[c] = ST_MOVE;
              dir_d[c]   = !dir_q[c];
            end else begin
              state_d[c] = ST_IDLE;
            end
          end else begin
            tmr_d[c] = tmr_q[c] + TMR_W'(1);
          end
        end

        default: begin
          state_d[c] = ST_IDLE;
          tmr_d[c]   = '0;
        end
      endcase

      if (state_d[c] == ST_DWELL) pend_next_car[floor_d[c]] = 1'b0;
      pending_d[c*N_FLOORS +: N_FLOORS] = pend_next_car;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      dir_q     <= '1;
      arrive_q  <= '0;
      moving_q  <= '0;
      door_q    <= '0;
      for (int c = 0; c < int'(N_CARS); c++) begin
        state_q[c] <= ST_IDLE;
        floor_q[c] <= '0;
        tmr_q[c]   <= '0;
      end
    end else begin
      pending_q <= pending_d;
      dir_q     <= dir_d;
      arrive_q  <= arrive_d;
      for (int c = 0; c < int'(N_CARS); c++) begin
        state_q[c]  <= state_d[c];
        floor_q[c]  <= floor_d[c];
        tmr_q[c]    <= tmr_d[c];
        moving_q[c] <= (state_d[c] == ST_MOVE);
        door_q[c]   <= (state_d[c] == ST_DWELL);
      end
    end
  end

  assign bus.pending_o   = pending_q;
  assign bus.car_dir_o   = dir_q;
  assign bus.moving_o    = moving_q;
  assign bus.door_open_o = door_q;
  assign bus.arrive_o    = arrive_q;

  for (genvar g = 0; g < int'(N_CARS); g++) begin : g_floor_out
    assign bus.car_floor_o[g*FLOOR_W +: FLOOR_W] = floor_q[g];
  end

endmodule
